// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg
//   Shared definitions for the SRAM memory arbiter: the controller state
//   encoding and the default address/data widths used as parameter defaults.
package memory_arbiter_pkg;

  localparam int DEFAULT_ADDR_W = 17;
  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter_grant.sv
// memory_arbiter_grant
//   Combinational grant selection. Channel 0 (video) always wins. Among
//   channels 1..NUM_CH-1 the search starts at 'pointer' and wraps from
//   NUM_CH-1 back to 1, so the first requesting channel found is granted.
//   Holding pointer at 1 gives fixed lowest-index-wins priority; a rotating
//   pointer (top level, ARB_ROUND_ROBIN_EN builds) gives round-robin.
// Ports:
//   requests  in  NUM_CH  per-channel request levels
//   pointer   in  PTR_W   first channel (1..NUM_CH-1) to consider
//   grant     out NUM_CH  one-hot grant, all zero when nothing requests
module memory_arbiter_grant #(
  parameter int NUM_CH = 3,
  parameter int PTR_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] requests,
  input  logic [PTR_W-1:0]  pointer,
  output logic [NUM_CH-1:0] grant
);

  logic found;
  int   pos;

  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = 0;
    if (requests[0]) begin
      grant[0] = 1'b1;
    end else begin
      // k is the distance from the pointer; the smallest distance wins.
      for (int k = 0; k < NUM_CH - 1; k++) begin
        pos = ((int'(pointer) - 1 + k) % (NUM_CH - 1)) + 1;
        for (int c = 1; c < NUM_CH; c++) begin
          if (!found && (c == pos) && requests[c]) begin
            grant[c] = 1'b1;
            found    = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Shares one asynchronous SRAM between NUM_CH requestors. Each access is
//   IDLE (grant + latch) -> ACCESS for ACCESS_CYCLES cycles -> DONE (ack).
//   Reads hold OE low through ACCESS and capture ramDataIn on the last ACCESS
//   cycle. Writes use ACCESS cycle 1 as address/data setup (WE high), pull WE
//   low for the remaining ACCESS cycles and keep driving data through DONE.
//
//   Handshake: a requester raises chReq[i] with chWrite/chAddress/chWriteData
//   valid and keeps it high until it sees chAck[i] (a one-cycle pulse). The
//   request fields are latched at grant, so later changes, or dropping chReq
//   before the ack, do not disturb the access in flight. chReadData is valid
//   in the ack cycle and holds until the next read completes.
//
//   Build option: define ARB_ROUND_ROBIN_EN for round-robin among channels
//   1..NUM_CH-1; otherwise they use fixed priority (lowest index wins).
//   Channel 0 always has top priority.
//
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   chReq/chWrite                per-channel request level and write flag
//   chAddress/chWriteData        per-channel address and write data (packed)
//   chAck                        per-channel one-cycle completion pulse
//   chReadData                   last read byte
//   ramAddress/ramDataOut        SRAM address and write data
//   ramDataIn                    SRAM read data
//   ramDataDrive                 data pin tristate enable (applied at top)
//   ramWriteEnable/OutputEnable  active-low SRAM strobes
//   state (internal)             controller state, arb_state_t
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_W        = DEFAULT_ADDR_W,
  parameter int DATA_W        = DEFAULT_DATA_W,
  parameter int NUM_CH        = 3,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        chReq,
  input  logic [NUM_CH-1:0]        chWrite,
  input  logic [NUM_CH*ADDR_W-1:0] chAddress,
  input  logic [NUM_CH*DATA_W-1:0] chWriteData,
  output logic [NUM_CH-1:0]        chAck,
  output logic [DATA_W-1:0]        chReadData,
  output logic [ADDR_W-1:0]        ramAddress,
  output logic [DATA_W-1:0]        ramDataOut,
  input  logic [DATA_W-1:0]        ramDataIn,
  output logic                     ramDataDrive,
  output logic                     ramWriteEnable,
  output logic                     ramOutputEnable
);

  localparam int PTR_W  = $clog2(NUM_CH);
  localparam int BEAT_W = $clog2(ACCESS_CYCLES);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(ACCESS_CYCLES - 1);

  arb_state_t        state, state_next;
  logic [BEAT_W-1:0] beat, beat_next;
  logic              start, last_beat;

  logic [NUM_CH-1:0] grant_new, grant_q;
  logic [PTR_W-1:0]  grant_ptr;
  logic              write_q;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_write;

  assign start     = (state == ST_IDLE) && (|chReq);
  assign last_beat = (state == ST_ACCESS) && (beat == LAST_BEAT);

  memory_arbiter_grant #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_grant (
    .requests (chReq),
    .pointer  (grant_ptr),
    .grant    (grant_new)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] rr_ptr, rr_ptr_next;

  // After serving channel k the next search starts at k+1, wrapping to 1.
  // A channel-0 grant leaves the pointer where it was.
  always_comb begin
    rr_ptr_next = rr_ptr;
    for (int c = 1; c < NUM_CH; c++) begin
      if (grant_new[c]) begin
        rr_ptr_next = (c == NUM_CH - 1) ? PTR_W'(1) : PTR_W'(c + 1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= PTR_W'(1);
    end else if (start) begin
      rr_ptr <= rr_ptr_next;
    end
  end

  assign grant_ptr = rr_ptr;
`else
  assign grant_ptr = PTR_W'(1);
`endif

  // Request fields of the granted channel (grant_new is one-hot or zero).
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant_new[c]) begin
        sel_addr  = sel_addr  | chAddress[c*ADDR_W +: ADDR_W];
        sel_wdata = sel_wdata | chWriteData[c*DATA_W +: DATA_W];
        sel_write = sel_write | chWrite[c];
      end
    end
  end

  // Controller state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      beat  <= '0;
    end else begin
      state <= state_next;
      beat  <= beat_next;
    end
  end

  // Next-state logic; beat counts ACCESS cycles from 0.
  always_comb begin
    state_next = state;
    beat_next  = '0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (last_beat) state_next = ST_DONE;
        else           beat_next  = beat + 1'b1;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Latched request and read-data capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_q    <= '0;
      write_q    <= 1'b0;
      ramAddress <= '0;
      ramDataOut <= '0;
      chReadData <= '0;
    end else begin
      if (start) begin
        grant_q    <= grant_new;
        write_q    <= sel_write;
        ramAddress <= sel_addr;
        ramDataOut <= sel_wdata;
      end
      if (last_beat && !write_q) begin
        chReadData <= ramDataIn;
      end
    end
  end

  // Strobes decode from registered state only. WE is held high on the first
  // ACCESS cycle (beat 0) to give address/data setup before the write pulse;
  // OE and WE are qualified by opposite values of write_q, so they can never
  // be low together, and both are high outside ACCESS.
  always_comb begin
    chAck           = (state == ST_DONE) ? grant_q : '0;
    ramOutputEnable = !((state == ST_ACCESS) && !write_q);
    ramWriteEnable  = !((state == ST_ACCESS) && write_q && (beat != '0));
    ramDataDrive    = write_q && ((state == ST_ACCESS) || (state == ST_DONE));
  end

endmodule
